// File: rtl/axi_lrsc_resv_ctrl.sv
// Reservation table for the AXI LR/SC adapter: LR sets, SC checks/clears, plain stores invalidate.
// One table update per cycle, chosen by a round-robin arbiter; SC results leave on a registered channel.
module axi_lrsc_resv_ctrl #(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned NUM_SLOTS      = 4,
   parameter int unsigned GRAN_BITS      = 3
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  lr_valid_i,
   output logic                                  lr_ready_o,
   input  logic [AXI_ID_WIDTH-1:0]               lr_id_i,
   input  logic [AXI_ADDR_WIDTH-1:0]             lr_addr_i,
   input  logic                                  sc_valid_i,
   output logic                                  sc_ready_o,
   input  logic [AXI_ID_WIDTH-1:0]               sc_id_i,
   input  logic [AXI_ADDR_WIDTH-1:0]             sc_addr_i,
   output logic                                  sc_rsp_valid_o,
   input  logic                                  sc_rsp_ready_i,
   output logic                                  sc_rsp_ok_o,
   input  logic                                  st_valid_i,
   output logic                                  st_ready_o,
   input  logic [AXI_ADDR_WIDTH-1:0]             st_addr_i,
   output logic [$clog2(NUM_SLOTS+1)-1:0]        resv_count_o
);

   localparam int unsigned GW = AXI_ADDR_WIDTH - GRAN_BITS;
   localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned CW = $clog2(NUM_SLOTS + 1);

   typedef enum logic [1:0] {
      REQ_SC = 2'd0,
      REQ_ST = 2'd1,
      REQ_LR = 2'd2
   } req_e;

   req_e                    rr_q, rr_d;
   logic [SW-1:0]           evict_q, evict_d;
   logic [NUM_SLOTS-1:0]    valid_q, valid_d;
   logic [AXI_ID_WIDTH-1:0] id_q   [NUM_SLOTS];
   logic [AXI_ID_WIDTH-1:0] id_d   [NUM_SLOTS];
   logic [GW-1:0]           gran_q [NUM_SLOTS];
   logic [GW-1:0]           gran_d [NUM_SLOTS];
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_ok_q, rsp_ok_d;
   logic [CW-1:0]           count_q, count_d;

   logic                    sc_elig;
   logic                    gnt_sc, gnt_st, gnt_lr;
   logic [GW-1:0]           lr_gran, sc_gran, st_gran;
   logic [NUM_SLOTS-1:0]    lr_id_hit, sc_id_hit, sc_gran_hit, st_gran_hit;
   logic                    sc_ok;
   logic                    lr_hit_found, free_found;
   logic [SW-1:0]           lr_hit_idx, free_idx, lr_idx;
   logic                    unused_addr_bits;

   assign lr_gran = lr_addr_i[AXI_ADDR_WIDTH-1:GRAN_BITS];
   assign sc_gran = sc_addr_i[AXI_ADDR_WIDTH-1:GRAN_BITS];
   assign st_gran = st_addr_i[AXI_ADDR_WIDTH-1:GRAN_BITS];
   assign unused_addr_bits = ^{lr_addr_i[GRAN_BITS-1:0], sc_addr_i[GRAN_BITS-1:0],
                               st_addr_i[GRAN_BITS-1:0]};

   // A new SC may only win if its response slot is free or is being drained this cycle.
   assign sc_elig = sc_valid_i && (!rsp_valid_q || sc_rsp_ready_i);

   always_comb begin
      gnt_sc = 1'b0;
      gnt_st = 1'b0;
      gnt_lr = 1'b0;
      if (!rst_i) begin
         case (rr_q)
            REQ_SC: begin
               if (sc_elig)         gnt_sc = 1'b1;
               else if (st_valid_i) gnt_st = 1'b1;
               else if (lr_valid_i) gnt_lr = 1'b1;
            end
            REQ_ST: begin
               if (st_valid_i)      gnt_st = 1'b1;
               else if (lr_valid_i) gnt_lr = 1'b1;
               else if (sc_elig)    gnt_sc = 1'b1;
            end
            default: begin
               if (lr_valid_i)      gnt_lr = 1'b1;
               else if (sc_elig)    gnt_sc = 1'b1;
               else if (st_valid_i) gnt_st = 1'b1;
            end
         endcase
      end
   end

   assign sc_ready_o = gnt_sc;
   assign st_ready_o = gnt_st;
   assign lr_ready_o = gnt_lr;

   // Per-slot match vectors and LR slot selection.
   always_comb begin
      lr_hit_found = 1'b0;
      free_found   = 1'b0;
      lr_hit_idx   = '0;
      free_idx     = '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         lr_id_hit[i]   = valid_q[i] && (id_q[i] == lr_id_i);
         sc_id_hit[i]   = valid_q[i] && (id_q[i] == sc_id_i);
         sc_gran_hit[i] = valid_q[i] && (gran_q[i] == sc_gran);
         st_gran_hit[i] = valid_q[i] && (gran_q[i] == st_gran);
         if (!lr_hit_found && lr_id_hit[i]) begin
            lr_hit_found = 1'b1;
            lr_hit_idx   = SW'(i);
         end
         if (!free_found && !valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = SW'(i);
         end
      end
      sc_ok  = |(sc_id_hit & sc_gran_hit);
      lr_idx = lr_hit_found ? lr_hit_idx : (free_found ? free_idx : evict_q);
   end

   always_comb begin
      rr_d        = rr_q;
      evict_d     = evict_q;
      valid_d     = valid_q;
      id_d        = id_q;
      gran_d      = gran_q;
      rsp_valid_d = rsp_valid_q;
      rsp_ok_d    = rsp_ok_q;
      count_d     = '0;

      if (gnt_sc) begin
         valid_d     = valid_q & ~sc_id_hit & ~(sc_ok ? sc_gran_hit : '0);
         rsp_valid_d = 1'b1;
         rsp_ok_d    = sc_ok;
         rr_d        = REQ_ST;
      end else if (sc_rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end

      if (gnt_st) begin
         valid_d = valid_q & ~st_gran_hit;
         rr_d    = REQ_LR;
      end

      if (gnt_lr) begin
         valid_d[lr_idx] = 1'b1;
         id_d[lr_idx]    = lr_id_i;
         gran_d[lr_idx]  = lr_gran;
         rr_d            = REQ_SC;
         // Round-robin victim only advances when the table was full.
         if (!lr_hit_found && !free_found) begin
            evict_d = (evict_q == SW'(NUM_SLOTS - 1)) ? '0 : evict_q + SW'(1);
         end
      end

      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         count_d = count_d + CW'(valid_d[i]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q        <= REQ_SC;
         evict_q     <= '0;
         valid_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_ok_q    <= 1'b0;
         count_q     <= '0;
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            id_q[i]   <= '0;
            gran_q[i] <= '0;
         end
      end else begin
         rr_q        <= rr_d;
         evict_q     <= evict_d;
         valid_q     <= valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ok_q    <= rsp_ok_d;
         count_q     <= count_d;
         id_q        <= id_d;
         gran_q      <= gran_d;
      end
   end

   assign sc_rsp_valid_o = rsp_valid_q;
   assign sc_rsp_ok_o    = rsp_ok_q;
   assign resv_count_o   = count_q;

endmodule
